// File: rtl/vote_ctrl_n.sv
// ---------------------------------------------------------------------------
// vote_ctrl_n : clocked N-voter ballot controller
//
// A start pulse in IDLE opens a voting window of at most WIN_CYC cycles.
// Each voter may cast one vote (vote_en[i] qualifies vote_yes[i]). The
// first vote from a voter is kept and later strobes are ignored. The window
// closes when the timer expires or when every voter has voted. abort cancels
// the window without publishing anything. A one-cycle TALLY state then
// publishes the held results with a single-cycle done pulse.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   start      open a voting window (sampled only in IDLE)
//   abort      cancel the open window, no result published
//   vote_en    [N]  per-voter vote strobe
//   vote_yes   [N]  per-voter ballot value, 1 = yes
//   busy       high while in VOTING or TALLY
//   done       one-cycle pulse when new results are valid
//   pass       motion passed
//   reject     motion failed
//   none_yes   no yes votes were counted
//   yes_cnt    [CW] number of yes votes
//   voted_cnt  [CW] number of voters that cast a vote
// ---------------------------------------------------------------------------
module vote_ctrl_n #(
  parameter int N         = 3,
  parameter int THRESH    = 2,
  parameter int CHAIR_EN  = 1,
  parameter int CHAIR_IDX = 2,
  parameter int WIN_CYC   = 8,
  localparam int CW       = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  vote_en,
  input  logic [N-1:0]  vote_yes,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          reject,
  output logic          none_yes,
  output logic [CW-1:0] yes_cnt,
  output logic [CW-1:0] voted_cnt
);

  // Timer holds WIN_CYC-1 down to 0; keep at least one bit.
  localparam int TW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [TW-1:0] TIMER_INIT = TW'(WIN_CYC - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [CW-1:0] THRESH_CW  = CW'(THRESH);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VOTING = 2'd1,
    S_TALLY  = 2'd2
  } state_t;

  // Count of set bits in a voter bus.
  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] cnt;
    cnt = CNT_ZERO;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  state_t        state_r;
  state_t        state_s;
  logic [N-1:0]  voted_r;
  logic [N-1:0]  ballot_r;
  logic [TW-1:0] timer_r;

  logic [N-1:0]  accept_s;
  logic          all_in_s;
  logic          timer_zero_s;
  logic [CW-1:0] yes_s;
  logic [CW-1:0] voted_s;
  logic          chair_ok_s;
  logic          pass_s;

  logic          busy_r;
  logic          done_r;
  logic          pass_r;
  logic          reject_r;
  logic          none_yes_r;
  logic [CW-1:0] yes_cnt_r;
  logic [CW-1:0] voted_cnt_r;

  // Vote acceptance and window-close conditions for the current cycle.
  always_comb begin
    accept_s     = vote_en & ~voted_r;        // first vote wins
    all_in_s     = &(voted_r | vote_en);      // votes in this cycle count
    timer_zero_s = (timer_r == TIMER_ZERO);
  end

  // Tally arithmetic, evaluated from the held ballot registers.
  always_comb begin
    yes_s   = popcount(ballot_r);
    voted_s = popcount(voted_r);
    if (CHAIR_EN == 0) begin
      chair_ok_s = 1'b1;
    end else begin
      chair_ok_s = ballot_r[CHAIR_IDX];
    end
    pass_s = (yes_s >= THRESH_CW) && chair_ok_s;
  end

  // Next-state logic; abort outranks window close in VOTING.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_VOTING;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_VOTING: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (timer_zero_s || all_in_s) begin
          state_s = S_TALLY;
        end else begin
          state_s = S_VOTING;
        end
      end
      S_TALLY: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Ballot, voted-mask and window timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voted_r  <= {N{1'b0}};
      ballot_r <= {N{1'b0}};
      timer_r  <= TIMER_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            voted_r  <= {N{1'b0}};
            ballot_r <= {N{1'b0}};
            timer_r  <= TIMER_INIT;
          end
        end
        S_VOTING: begin
          if (abort) begin
            voted_r  <= {N{1'b0}};
            ballot_r <= {N{1'b0}};
            timer_r  <= TIMER_ZERO;
          end else begin
            // Ballot bits of unvoted voters are still 0, so OR-in is safe.
            voted_r  <= voted_r | accept_s;
            ballot_r <= ballot_r | (accept_s & vote_yes);
            if (!timer_zero_s) begin
              timer_r <= timer_r - TIMER_ONE;
            end
          end
        end
        default: begin
          voted_r  <= voted_r;
          ballot_r <= ballot_r;
          timer_r  <= timer_r;
        end
      endcase
    end
  end

  // Published results and status outputs; results move only on TALLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      reject_r    <= 1'b0;
      none_yes_r  <= 1'b0;
      yes_cnt_r   <= CNT_ZERO;
      voted_cnt_r <= CNT_ZERO;
    end else begin
      busy_r <= (state_s != S_IDLE);
      if (state_r == S_TALLY) begin
        done_r      <= 1'b1;
        pass_r      <= pass_s;
        reject_r    <= !pass_s;
        none_yes_r  <= (yes_s == CNT_ZERO);
        yes_cnt_r   <= yes_s;
        voted_cnt_r <= voted_s;
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign reject    = reject_r;
  assign none_yes  = none_yes_r;
  assign yes_cnt   = yes_cnt_r;
  assign voted_cnt = voted_cnt_r;

endmodule

// File: doc/vote_ctrl_n.md
Name: vote_ctrl_n

Overview:
Parametrised, clocked N-voter ballot controller that generalises the three-person voting circuit.
- A `start` pulse opens a timed voting window; one vote per voter is accepted.
- On close, the block tallies yes votes, applies threshold and optional chair-approval rules, and publishes held results with a one-cycle `done` pulse.
- Sits between voter input synchronisers/debouncers and the display/indicator logic.

Parameters:
N, 3, number of voters (2..16)
THRESH, 2, minimum yes count for pass (1..N)
CHAIR_EN, 1, 1 = pass additionally requires chair voter yes; 0 = pure threshold
CHAIR_IDX, 2, bit index of chair voter in vote buses (0..N-1)
WIN_CYC, 8, voting window length in clock cycles (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  open window; sampled only in IDLE
abort  in  1  cancel open window; no result published
vote_en  in  N  per-voter vote strobe
vote_yes  in  N  per-voter ballot value (1 = yes), qualified by vote_en[i]
busy  out  1  high in VOTING and TALLY
done  out  1  one-cycle pulse when new results valid
pass  out  1  result: motion passed
reject  out  1  result: motion failed
none_yes  out  1  result: zero yes votes
yes_cnt  out  CW  yes votes counted, CW = $clog2(N+1)
voted_cnt  out  CW  voters who cast a vote in the window

Behaviour:
Reset:
- `rst`=1 forces state IDLE asynchronously.
- Clears all outputs, ballot/voted registers, and the timer.
- Reset mid-window discards all votes; no `done` is produced.

States:
- IDLE:
  - `busy`=0.
  - `start`=1 at an edge -> VOTING.
  - On entry to VOTING: voted[]=0, ballot[]=0, timer=WIN_CYC-1.
  - Previous results stay held.
- VOTING:
  - Each cycle, for each i with vote_en[i]=1 and voted[i]=0: voted[i]<=1, ballot[i]<=vote_yes[i].
  - vote_en[i] with voted[i]=1 is ignored (first vote wins; no revotes).
  - Timer decrements each cycle.
  - Exit to TALLY at the end of the cycle in which timer==0, or in which (voted | vote_en) is all ones.
  - Votes presented in the exit cycle are accepted.
  - The window therefore lasts at most WIN_CYC cycles.
  - `abort`=1 -> IDLE, votes discarded, outputs unchanged, no `done`.
  - `abort` takes priority over exit and over votes in the same cycle.
  - `start` is ignored while in VOTING.
- TALLY:
  - Single cycle; always -> IDLE.
  - Registers:
    - yes_cnt = popcount(ballot)
    - voted_cnt = popcount(voted)
    - pass = (yes_cnt >= THRESH) && (!CHAIR_EN || ballot[CHAIR_IDX])
    - reject = !pass
    - none_yes = (yes_cnt == 0)
  - `done`<=1 on the same edge. Results and `done` are visible in the cycle after TALLY; `done` returns to 0 one cycle later.
  - `abort` and `start` are ignored in TALLY.

Arithmetic and timing rules:
- Non-voters count as no for the tally; abstentions = N - voted_cnt.
- Counts are unsigned, width CW; no overflow is possible.
- pass/reject/none_yes/yes_cnt/voted_cnt change only on the TALLY edge or on reset.
- Latency: the last accepted vote at edge k gives TALLY at edge k+1 and `done` high during cycle k+1..k+2.

Default configuration:
- N=3, THRESH=2, CHAIR_EN=1, CHAIR_IDX=2.
- This reproduces the three-person rule: pass = A & (B | C); none_yes = no yes votes.

Test Plan:
1. Defaults, start, then vote_en=3'b111 with vote_yes=3'b101 in one cycle -> window closes immediately; done 1 cycle later; pass=1, reject=0, yes_cnt=2, voted_cnt=3, none_yes=0.
2. Defaults, all vote with vote_yes=3'b011 (chair no) -> pass=0, reject=1, yes_cnt=2.
3. Defaults, start, no votes -> VOTING lasts exactly 8 cycles; done pulses once; yes_cnt=0, voted_cnt=0, none_yes=1, reject=1; busy high for 9 cycles.
4. Voter 0 votes yes, then votes no two cycles later; chair yes; voter 1 abstains; timeout -> first vote kept; yes_cnt=2, voted_cnt=2, pass=1.
5. Abort in 3rd VOTING cycle after a 3'b101 vote -> IDLE, no done, prior results unchanged. Then rst asserted mid-window in a new ballot -> all outputs 0 immediately (asynchronous), no done.
6. N=5, THRESH=3, CHAIR_EN=0, votes 5'b10110 -> pass=1, yes_cnt=3. Then 5'b10010 -> pass=0, yes_cnt=2. Also start held high during VOTING -> no restart.
